// File: rtl/operand_bank_pkg.sv
// Shared encodings for the operand bank reducer: ALU op codes and FSM states.
package operand_bank_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_XOR = 2'b01,
      OP_MAX = 2'b10,
      OP_MIN = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/operand_bank_alu.sv
// Combinational reduction step y = f(a, b); carry reports ADD overflow.
// OPERAND_BANK_SAT_EN makes ADD clamp to all ones on carry instead of wrapping.
module operand_bank_alu
   import operand_bank_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  op_e          op,
   output logic [W-1:0] y,
   output logic         carry
);

   logic [W:0] w_sum;

   assign w_sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      y     = a;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            carry = w_sum[W];
`ifdef OPERAND_BANK_SAT_EN
            y = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
`else
            y = w_sum[W-1:0];
`endif
         end
         OP_XOR: y = a ^ b;
         OP_MAX: y = (a > b) ? a : b;
         OP_MIN: y = (a < b) ? a : b;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/operand_bank_seq.sv
// Channel bank plus sequential reducer: one channel folded into acc per RUN cycle.
// Build option OPERAND_BANK_SAT_EN (saturating ADD) lives in operand_bank_alu.
module operand_bank_seq
   import operand_bank_pkg::*;
#(
   parameter int NCH = 4,
   parameter int W   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   ld_data,
   input  logic [NCH-1:0] ld_sel,
   input  logic [1:0]     op,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   result,
   output logic           ovf
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_e                r_state, w_next;
   logic [NCH-1:0][W-1:0] r_ch;
   logic [W-1:0]          r_acc;
   logic [IW-1:0]         r_idx;
   op_e                   r_op;
   logic                  r_iovf;
   logic [W-1:0]          r_result;
   logic                  r_ovf;

   logic                  w_idle, w_load, w_go, w_last;
   logic [W-1:0]          w_y;
   logic                  w_carry;

   assign w_idle = (r_state == ST_IDLE);
   assign w_load = w_idle && (|ld_sel);
   // A load in the same cycle wins over start.
   assign w_go   = w_idle && start && !(|ld_sel);
   assign w_last = (r_idx == IW'(NCH - 1));

   operand_bank_alu #(.W(W)) u_alu (
      .a     (r_acc),
      .b     (r_ch[r_idx]),
      .op    (r_op),
      .y     (w_y),
      .carry (w_carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_go) w_next = (NCH > 1) ? ST_RUN : ST_DONE;
         ST_RUN:  if (w_last) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ch <= '0;
      end else if (w_load) begin
         for (int i = 0; i < NCH; i++)
            if (ld_sel[i]) r_ch[i] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_idx    <= '0;
         r_op     <= OP_ADD;
         r_iovf   <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
      end else if (w_go) begin
         r_op   <= op_e'(op);
         r_acc  <= r_ch[0];
         r_idx  <= IW'(1);
         r_iovf <= 1'b0;
         if (NCH == 1) begin
            r_result <= r_ch[0];
            r_ovf    <= 1'b0;
         end
      end else if (r_state == ST_RUN) begin
         r_acc  <= w_y;
         r_idx  <= r_idx + IW'(1);
         r_iovf <= r_iovf | w_carry;
         // Publish on the final step so result is valid throughout DONE.
         if (w_last) begin
            r_result <= w_y;
            r_ovf    <= r_iovf | w_carry;
         end
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_operand_bank_seq.sv
// Directed bench for operand_bank_seq with a reduction-level reference model.
module tb_operand_bank_seq;

   localparam int NCH = 4;
   localparam int W   = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   ld_data;
   logic [NCH-1:0] ld_sel;
   logic [1:0]     op;
   logic           start;
   logic           busy, done, ovf;
   logic [W-1:0]   result;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   operand_bank_seq #(.NCH(NCH), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_sel(ld_sel), .op(op),
      .start(start), .busy(busy), .done(done), .result(result), .ovf(ovf)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Whole-bank reduction from the op rules; ADD uses the true integer total.
   function automatic logic [W:0] reduce(input logic [1:0] o, input logic [NCH-1:0][W-1:0] c);
      int tot;
      logic [W-1:0] r;
      logic v;
      tot = 0; v = 1'b0; r = c[0];
      case (o)
         2'd0: begin
            for (int i = 0; i < NCH; i++) tot += int'(c[i]);
            v = (tot >= (1 << W));
`ifdef OPERAND_BANK_SAT_EN
            r = v ? {W{1'b1}} : W'(tot);
`else
            r = W'(tot);
`endif
         end
         2'd1: for (int i = 1; i < NCH; i++) r = r ^ c[i];
         2'd2: for (int i = 1; i < NCH; i++) if (c[i] > r) r = c[i];
         default: for (int i = 1; i < NCH; i++) if (c[i] < r) r = c[i];
      endcase
      return {v, r};
   endfunction

   // Model: bank contents, a countdown of remaining busy cycles, and published result.
   logic [NCH-1:0][W-1:0] m_ch = '0;
   int                    m_cnt = 0;
   logic [W-1:0]          m_res = '0, p_res = '0;
   logic                  m_ovf = 1'b0, p_ovf = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ch <= '0; m_cnt <= 0; m_res <= '0; m_ovf <= 1'b0;
      end else if (m_cnt == 0) begin
         if (ld_sel != '0) begin
            for (int i = 0; i < NCH; i++) if (ld_sel[i]) m_ch[i] <= ld_data;
         end else if (start) begin
            m_cnt <= NCH;
            {p_ovf, p_res} <= reduce(op, m_ch);
            if (NCH == 1) {m_ovf, m_res} <= reduce(op, m_ch);
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) {m_ovf, m_res} <= {p_ovf, p_res};
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_busy",   busy,   (m_cnt != 0));
         chk("mdl_done",   done,   (m_cnt == 1));
         chk("mdl_result", result, m_res);
         chk("mdl_ovf",    ovf,    m_ovf);
      end
   end

   task automatic load4(input logic [W-1:0] a, b, c, d);
      logic [NCH-1:0][W-1:0] v;
      v = {d, c, b, a};
      for (int i = 0; i < NCH; i++) begin
         @(negedge clk);
         ld_sel = NCH'(1) << i;
         ld_data = v[i];
      end
      @(negedge clk);
      ld_sel = '0;
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] er, input logic eo, input string nm);
      int lat, nb;
      @(negedge clk);
      op = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1; nb = 0;
      while (!done && lat < 20) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
      end
      if (busy) nb++;
      chk({nm, "_lat"},  lat,    NCH);
      chk({nm, "_res"},  result, er);
      chk({nm, "_ovf"},  ovf,    eo);
      chk({nm, "_busy"}, nb,     NCH);
      @(negedge clk);
      chk({nm, "_done_off"}, done, 1'b0);
   endtask

   initial begin
      int ndone;
      rst_n = 1'b0; ld_data = '0; ld_sel = '0; op = 2'd0; start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 1'b0);
      chk_en = 1'b1;
      rst_n = 1'b1;

      load4(4'd1, 4'd2, 4'd3, 4'd4);
      run(2'd0, 4'hA, 1'b0, "add1234");

      // start alongside a load: load wins, no run starts
      @(negedge clk);
      ld_sel = 4'b0001; ld_data = 4'd5; start = 1'b1;
      @(negedge clk);
      ld_sel = '0; start = 1'b0;
      chk("ldstart_busy", busy, 1'b0);
      @(negedge clk);
      chk("ldstart_busy2", busy, 1'b0);
      run(2'd0, 4'hE, 1'b0, "add_ch0upd");

      load4(4'd8, 4'd8, 4'd8, 4'd8);
`ifdef OPERAND_BANK_SAT_EN
      run(2'd0, 4'hF, 1'b1, "add_sat");
`else
      run(2'd0, 4'h0, 1'b1, "add_wrap");
`endif

      load4(4'd3, 4'd9, 4'd2, 4'd7);
      run(2'd2, 4'h9, 1'b0, "max");
      run(2'd3, 4'h2, 1'b0, "min");
      run(2'd1, 4'hF, 1'b0, "xor");

      // loads, restart and op change during RUN must all be ignored
      @(negedge clk);
      op = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b1; ld_sel = '1; ld_data = '0; op = 2'd3;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         if (k == 2) begin start = 1'b0; ld_sel = '0; end
         @(negedge clk);
      end
      chk("haz_ndone", ndone, 1);
      chk("haz_result", result, 4'h9);
      run(2'd3, 4'h2, 1'b0, "haz_bank_kept");

      // reset two cycles into a run aborts it
      @(negedge clk);
      op = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_result", result, 0);
      chk("abort_done", done, 1'b0);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_nodone", ndone, 0);
      run(2'd0, 4'h0, 1'b0, "add_zero");

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
